video_timing_gen: RTL and testbench

//   Parametrised VGA-class raster timing generator. Successor to the fixed 640x480 sync generator.

---
 rtl/video_timing_gen.sv | 94 +++++++++
 tb/tb_video_timing_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with registered, mutually aligned
// position, sync, blank and strobe outputs plus a completed-frame counter.
module video_timing_gen #(
   parameter int   H_DISPLAY = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_DISPLAY = 480,
   parameter int   V_BOTTOM  = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_TOP     = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   CW        = 10,
   parameter int   FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   output logic [CW-1:0]      hpos,
   output logic [CW-1:0]      vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               hblank,
   output logic               vblank,
   output logic               display_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_DISP = CW'(H_DISPLAY);
   localparam logic [CW-1:0] V_DISP = CW'(V_DISPLAY);
   localparam logic [CW-1:0] HS_BEG = CW'(H_DISPLAY + H_FRONT);
   localparam logic [CW-1:0] HS_END = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CW-1:0] VS_BEG = CW'(V_DISPLAY + V_BOTTOM);
   localparam logic [CW-1:0] VS_END = CW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

   logic [CW-1:0]      r_hpos, r_vpos;
   logic               r_hsync, r_vsync, r_hblank, r_vblank, r_display_on;
   logic               r_line_start, r_frame_start;
   logic [FRAME_W-1:0] r_frame_count;
   logic               w_h_wrap, w_v_wrap;
   logic [CW-1:0]      w_h_next, w_v_next;

   // Flags are decoded from the next position so they load together with it.
   always_comb begin
      w_h_wrap = r_hpos == H_LAST;
      w_v_wrap = r_vpos == V_LAST;
      w_h_next = w_h_wrap ? '0 : r_hpos + 1'b1;
      w_v_next = !w_h_wrap ? r_vpos : w_v_wrap ? '0 : r_vpos + 1'b1;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_hpos        <= '0;
         r_vpos        <= '0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_hblank      <= 1'b0;
         r_vblank      <= 1'b0;
         r_display_on  <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_line_start  <= pix_en & w_h_wrap;
         r_frame_start <= pix_en & w_h_wrap & w_v_wrap;
         if (pix_en) begin
            r_hpos       <= w_h_next;
            r_vpos       <= w_v_next;
            r_hsync      <= (w_h_next >= HS_BEG && w_h_next <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync      <= (w_v_next >= VS_BEG && w_v_next <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
            r_hblank     <= w_h_next >= H_DISP;
            r_vblank     <= w_v_next >= V_DISP;
            r_display_on <= w_h_next < H_DISP && w_v_next < V_DISP;
            if (w_h_wrap && w_v_wrap) r_frame_count <= r_frame_count + 1'b1;
         end
      end

   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign hblank      = r_hblank;
   assign vblank      = r_vblank;
   assign display_on  = r_display_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: two small-geometry instances (active-low and active-high sync) checked every
// cycle against a tick-count arithmetic model, plus literal spot checks of reset, wrap and frame timing.
module tb_video_timing_gen;
   logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
   always #5 clk = ~clk;

   logic [5:0] a_h, a_v;
   logic [1:0] a_fc;
   logic a_hs, a_vs, a_hb, a_vb, a_don, a_ls, a_fs;
   logic [4:0] b_h, b_v;
   logic [2:0] b_fc;
   logic b_hs, b_vs, b_hb, b_vb, b_don, b_ls, b_fs;

   video_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(6), .FRAME_W(2)) ua (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hpos(a_h), .vpos(a_v), .hsync(a_hs), .vsync(a_vs),
      .hblank(a_hb), .vblank(a_vb), .display_on(a_don), .line_start(a_ls), .frame_start(a_fs),
      .frame_count(a_fc));

   video_timing_gen #(.H_DISPLAY(6), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(2),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(5), .FRAME_W(3)) ub (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hpos(b_h), .vpos(b_v), .hsync(b_hs), .vsync(b_vs),
      .hblank(b_hb), .vblank(b_vb), .display_on(b_don), .line_start(b_ls), .frame_start(b_fs),
      .frame_count(b_fc));

   int n_chk = 0, n_fail = 0;
   int t_cnt = 0;
   bit last_en = 1'b0, run = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Everything the generator shows is a function of how many enabled ticks have elapsed since reset.
   always @(posedge clk or posedge reset)
      if (reset) begin
         t_cnt   <= 0;
         last_en <= 1'b0;
      end else begin
         last_en <= pix_en;
         if (pix_en) t_cnt <= t_cnt + 1;
      end

   task automatic check_one(input string nm, input int hd, hf, hs, hb, vd, vb, vs, vtop,
                            input bit hp, vp, input int fw,
                            input logic [31:0] h, v, fc, input logic hsy, vsy, hbl, vbl, don, ls, fs);
      int ht, vt, eh, ev, efc;
      ht  = hd + hf + hs + hb;
      vt  = vd + vb + vs + vtop;
      eh  = t_cnt % ht;
      ev  = (t_cnt / ht) % vt;
      efc = (t_cnt / (ht * vt)) % (1 << fw);
      chk({nm, ".hpos"}, h, eh);
      chk({nm, ".vpos"}, v, ev);
      chk({nm, ".frame_count"}, fc, efc);
      chk({nm, ".hsync"}, 32'(hsy), 32'((eh >= hd + hf && eh < hd + hf + hs) ? hp : !hp));
      chk({nm, ".vsync"}, 32'(vsy), 32'((ev >= vd + vb && ev < vd + vb + vs) ? vp : !vp));
      chk({nm, ".hblank"}, 32'(hbl), 32'(eh >= hd));
      chk({nm, ".vblank"}, 32'(vbl), 32'(ev >= vd));
      chk({nm, ".display_on"}, 32'(don), 32'(eh < hd && ev < vd));
      chk({nm, ".line_start"}, 32'(ls), 32'(last_en && eh == 0));
      chk({nm, ".frame_start"}, 32'(fs), 32'(last_en && eh == 0 && ev == 0));
   endtask

   always @(negedge clk)
      if (run) begin
         check_one("A", 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 2,
                   32'(a_h), 32'(a_v), 32'(a_fc), a_hs, a_vs, a_hb, a_vb, a_don, a_ls, a_fs);
         check_one("B", 6, 1, 2, 1, 3, 1, 1, 2, 1'b1, 1'b1, 3,
                   32'(b_h), 32'(b_v), 32'(b_fc), b_hs, b_vs, b_hb, b_vb, b_don, b_ls, b_fs);
      end

   initial begin
      int fexp, nfs, last_t, waited;
      #1 reset = 1'b1;
      #1;
      chk("reset_no_clk.hpos", 32'(a_h), 0);
      chk("reset_no_clk.hsync_lo", 32'(a_hs), 1);
      chk("reset_no_clk.hsync_hi", 32'(b_hs), 0);
      chk("reset_no_clk.display_on", 32'(a_don), 1);
      run = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset.vsync_lo", 32'(a_vs), 1);
      chk("reset.vsync_hi", 32'(b_vs), 0);
      chk("reset.frame_count", 32'(a_fc), 0);
      chk("reset.strobes", 32'({a_ls, a_fs}), 0);
      reset  = 1'b0;
      pix_en = 1'b1;
      repeat (15) @(negedge clk);
      chk("first_line.hpos", 32'(a_h), 0);
      chk("first_line.vpos", 32'(a_v), 1);
      chk("first_line.line_start", 32'(a_ls), 1);
      chk("first_line.frame_start", 32'(a_fs), 0);
      // Four full frames: frame_count must read 1,2,3,0 and frame_start recurs every 120 ticks.
      fexp = 1; nfs = 0; last_t = 0;
      repeat (500) begin
         @(negedge clk);
         if (a_fs) begin
            chk("frame.count_seq", 32'(a_fc), 32'(fexp));
            chk("frame.with_line_start", 32'(a_ls), 1);
            if (nfs > 0) chk("frame.period", 32'(t_cnt - last_t), 120);
            last_t = t_cnt;
            fexp = (fexp + 1) % 4;
            nfs++;
         end
      end
      chk("frame.pulse_count", 32'(nfs), 4);
      repeat (2000) begin
         pix_en = $urandom_range(0, 1) == 1;
         @(negedge clk);
         if (!last_en) chk("idle.no_strobe", 32'({a_ls, a_fs, b_ls, b_fs}), 0);
      end
      pix_en = 1'b1;
      waited = 0;
      while (!(a_h == 6'd10 && a_v == 6'd5) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("midreset.reach_target", 32'(waited < 200), 1);
      #2 reset = 1'b1;
      #1;
      chk("midreset.hpos", 32'(a_h), 0);
      chk("midreset.vpos", 32'(a_v), 0);
      chk("midreset.hsync", 32'({a_hs, b_hs}), 32'b10);
      chk("midreset.vblank_don", 32'({a_vb, a_don}), 32'b01);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (300) begin
         pix_en = $urandom_range(0, 3) != 0;
         @(negedge clk);
      end
      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
